// File: rtl/reaction_pkg.sv
// reaction_pkg: shared definitions for the reaction tester sequencer.
// Contents: state encoding (also the 3-bit debug code on the state port),
// datapath widths, LFSR seed/taps and the LFSR step function.
package reaction_pkg;

  localparam int TIME_W  = 14;  // elapsed / result / best times, binary ticks
  localparam int DELAY_W = 9;   // randomised wait countdown
  localparam int LFSR_W  = 8;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_ARMED = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  // Galois right-shift LFSR: feed the outgoing LSB back through the taps.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/reaction_sequencer_if.sv
// reaction_sequencer_if: button inputs and counter/display outputs of the
// reaction sequencer.
//   master: drives request_test/stop_test, observes everything else.
//   slave : the sequencer itself.
// Signalling: request_test and stop_test are plain levels (edge detected in
// the sequencer, no handshake); count_enable and count_clear are single-cycle
// pulses that the BCD counter must accept unconditionally (no back-pressure);
// all remaining outputs are registered levels.
interface reaction_sequencer_if;
  import reaction_pkg::*;

  logic              request_test;
  logic              stop_test;
  logic              test_active;
  logic              count_enable;
  logic              count_clear;
  logic              result_valid;
  logic [TIME_W-1:0] result_time;
  logic [TIME_W-1:0] best_time;
  logic              best_valid;
  logic              false_start;
  logic              timeout;
  logic [2:0]        state;

  modport master (
    output request_test, stop_test,
    input  test_active, count_enable, count_clear, result_valid, result_time,
           best_time, best_valid, false_start, timeout, state
  );

  modport slave (
    input  request_test, stop_test,
    output test_active, count_enable, count_clear, result_valid, result_time,
           best_time, best_valid, false_start, timeout, state
  );

endinterface

// File: rtl/tick_gen.sv
// tick_gen: 1/100 s tick divider.
// Ports: CLOCK_50 (clock), reset (sync, active-high), restart (zero the
// divider this cycle), tick (high while the divider sits at its terminal
// count, i.e. one cycle in every TICK_DIV).
module tick_gen #(
  parameter int TICK_DIV = 500000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/reaction_sequencer.sv
// reaction_sequencer: central FSM of the reaction tester.
// Sequence: IDLE -> WAIT (randomised delay) -> ARMED (timed window) -> DONE,
// or FAULT on a false start / timeout.
// Ports: CLOCK_50 (clock), reset (sync, active-high), bus (slave modport:
// request_test/stop_test buttons in; test_active, count_enable, count_clear,
// result_valid, result_time, best_time, best_valid, false_start, timeout and
// the debug state code out). Every output comes straight from a register.
module reaction_sequencer
  import reaction_pkg::*;
#(
  parameter int TICK_DIV        = 500000,
  parameter int MIN_DELAY_TICKS = 100,
  parameter int DELAY_SPAN      = 256,
  parameter int RANDOM_EN       = 1,
  parameter int TIMEOUT_TICKS   = 9999
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  reaction_sequencer_if.slave bus
);

  if (TICK_DIV < 2) begin : g_bad_div
    $error("TICK_DIV must be at least 2");
  end
  if (MIN_DELAY_TICKS < 1 || MIN_DELAY_TICKS + DELAY_SPAN - 1 > 511) begin : g_bad_delay
    $error("MIN_DELAY_TICKS + DELAY_SPAN - 1 must fit the 9-bit delay counter");
  end
  if (DELAY_SPAN < 2 || DELAY_SPAN > 256 || (DELAY_SPAN & (DELAY_SPAN - 1)) != 0) begin : g_bad_span
    $error("DELAY_SPAN must be a power of two in 2..256");
  end
  if (TIMEOUT_TICKS < 1 || TIMEOUT_TICKS > 16383) begin : g_bad_timeout
    $error("TIMEOUT_TICKS must be in 1..16383");
  end

  localparam logic [TIME_W-1:0]  TIMEOUT_VAL = TIME_W'(TIMEOUT_TICKS);
  localparam logic [DELAY_W-1:0] DELAY_MIN   = DELAY_W'(MIN_DELAY_TICKS);
  localparam logic [DELAY_W-1:0] DELAY_MASK  = DELAY_W'(DELAY_SPAN - 1);

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic                stop_q, stop_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [DELAY_W-1:0]  delay_q, delay_d;
  logic [TIME_W-1:0]   elapsed_q, elapsed_d;
  logic [TIME_W-1:0]   result_q, result_d;
  logic [TIME_W-1:0]   best_q, best_d;
  logic                best_valid_q, best_valid_d;
  logic                false_start_q, false_start_d;
  logic                timeout_q, timeout_d;
  logic                count_enable_q, count_enable_d;
  logic                count_clear_q, count_clear_d;
  logic                test_active_q, test_active_d;
  logic                result_valid_q, result_valid_d;

  logic                req_edge, stop_edge;
  logic                tick, restart;
  logic [DELAY_W-1:0]  delay_load;
  logic [TIME_W-1:0]   elapsed_inc;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .restart  (restart),
    .tick     (tick)
  );

  assign req_edge    = bus.request_test & ~req_q;
  assign stop_edge   = bus.stop_test & ~stop_q;
  assign elapsed_inc = elapsed_q + TIME_W'(1);
  assign delay_load  = DELAY_MIN +
                       ((RANDOM_EN != 0) ? ({1'b0, lfsr_q} & DELAY_MASK) : '0);

  always_comb begin
    state_d        = state_q;
    req_d          = bus.request_test;
    stop_d         = bus.stop_test;
    lfsr_d         = lfsr_next(lfsr_q);
    delay_d        = delay_q;
    elapsed_d      = elapsed_q;
    result_d       = result_q;
    best_d         = best_q;
    best_valid_d   = best_valid_q;
    false_start_d  = false_start_q;
    timeout_d      = timeout_q;
    count_enable_d = 1'b0;
    count_clear_d  = 1'b0;
    restart        = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_FAULT: begin
        if (req_edge) begin
          state_d       = ST_WAIT;
          count_clear_d = 1'b1;
          restart       = 1'b1;
          elapsed_d     = '0;
          false_start_d = 1'b0;
          timeout_d     = 1'b0;
          delay_d       = delay_load;
        end
      end
      ST_WAIT: begin
        if (stop_edge) begin
          state_d       = ST_FAULT;
          false_start_d = 1'b1;
        end else if (tick) begin
          delay_d = delay_q - DELAY_W'(1);
          if (delay_q == DELAY_W'(1)) begin
            state_d = ST_ARMED;
            restart = 1'b1;
          end
        end
      end
      ST_ARMED: begin
        // A stop coinciding with a tick wins; that tick is not counted.
        if (stop_edge) begin
          state_d  = ST_DONE;
          result_d = elapsed_q;
          if (!best_valid_q || elapsed_q < best_q) begin
            best_d       = elapsed_q;
            best_valid_d = 1'b1;
          end
        end else if (tick) begin
          elapsed_d      = elapsed_inc;
          count_enable_d = 1'b1;
          if (elapsed_inc == TIMEOUT_VAL) begin
            state_d   = ST_FAULT;
            timeout_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Level outputs are registered from the next state so they line up with state_q.
    test_active_d  = (state_d == ST_ARMED);
    result_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      req_q          <= 1'b0;
      stop_q         <= 1'b0;
      lfsr_q         <= LFSR_SEED;
      delay_q        <= '0;
      elapsed_q      <= '0;
      result_q       <= '0;
      best_q         <= '1;
      best_valid_q   <= 1'b0;
      false_start_q  <= 1'b0;
      timeout_q      <= 1'b0;
      count_enable_q <= 1'b0;
      count_clear_q  <= 1'b0;
      test_active_q  <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_q          <= req_d;
      stop_q         <= stop_d;
      lfsr_q         <= lfsr_d;
      delay_q        <= delay_d;
      elapsed_q      <= elapsed_d;
      result_q       <= result_d;
      best_q         <= best_d;
      best_valid_q   <= best_valid_d;
      false_start_q  <= false_start_d;
      timeout_q      <= timeout_d;
      count_enable_q <= count_enable_d;
      count_clear_q  <= count_clear_d;
      test_active_q  <= test_active_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign bus.test_active  = test_active_q;
  assign bus.count_enable = count_enable_q;
  assign bus.count_clear  = count_clear_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result_time  = result_q;
  assign bus.best_time    = best_q;
  assign bus.best_valid   = best_valid_q;
  assign bus.false_start  = false_start_q;
  assign bus.timeout      = timeout_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_reaction_sequencer.sv
// tb_reaction_sequencer: table-driven bench for reaction_sequencer with
// TICK_DIV=4, MIN_DELAY_TICKS=3, RANDOM_EN=0, TIMEOUT_TICKS=20.
// Each table row holds button levels for a number of cycles, then the
// expected registered outputs and the pulse/active counts seen meanwhile.
module tb_reaction_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   ce_n, clr_n, act_n;

  reaction_sequencer_if bus();

  reaction_sequencer #(
    .TICK_DIV        (4),
    .MIN_DELAY_TICKS (3),
    .DELAY_SPAN      (256),
    .RANDOM_EN       (0),
    .TIMEOUT_TICKS   (20)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired before the test sequence completed");
    $fatal(1, "watchdog");
  end

  // Pulse / activity counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.count_enable) ce_n++;
    if (bus.count_clear)  clr_n++;
    if (bus.test_active)  act_n++;
  end

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic run_cycles(input logic req, input logic stop, input int cyc);
    bus.request_test = req;
    bus.stop_test    = stop;
    ce_n = 0; clr_n = 0; act_n = 0;
    repeat (cyc) @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic req; logic stop; int cyc;
    int st; logic rv; int rt; int bt; logic bv; logic fs; logic to;
    int ce; int clr; int act;
  } vec_t;

  localparam int NV = 33;
  vec_t tbl[NV];

  initial begin
    //            req stop cyc  st rv rt  bt       bv fs to  ce clr act
    tbl[0]  = '{1'b1, 1'b0, 12, 1, 1'b0, 0, 16383, 1'b0, 1'b0, 1'b0, 0, 1, 0};
    tbl[1]  = '{1'b0, 1'b0, 1,  2, 1'b0, 0, 16383, 1'b0, 1'b0, 1'b0, 0, 0, 1};
    tbl[2]  = '{1'b0, 1'b0, 20, 2, 1'b0, 0, 16383, 1'b0, 1'b0, 1'b0, 5, 0, 20};
    tbl[3]  = '{1'b0, 1'b1, 1,  3, 1'b1, 5, 5,     1'b1, 1'b0, 1'b0, 0, 0, 0};
    tbl[4]  = '{1'b0, 1'b0, 2,  3, 1'b1, 5, 5,     1'b1, 1'b0, 1'b0, 0, 0, 0};
    tbl[5]  = '{1'b1, 1'b0, 12, 1, 1'b0, 5, 5,     1'b1, 1'b0, 1'b0, 0, 1, 0};
    tbl[6]  = '{1'b0, 1'b0, 1,  2, 1'b0, 5, 5,     1'b1, 1'b0, 1'b0, 0, 0, 1};
    tbl[7]  = '{1'b0, 1'b0, 28, 2, 1'b0, 5, 5,     1'b1, 1'b0, 1'b0, 7, 0, 28};
    tbl[8]  = '{1'b0, 1'b1, 1,  3, 1'b1, 7, 5,     1'b1, 1'b0, 1'b0, 0, 0, 0};
    tbl[9]  = '{1'b0, 1'b0, 1,  3, 1'b1, 7, 5,     1'b1, 1'b0, 1'b0, 0, 0, 0};
    tbl[10] = '{1'b1, 1'b0, 12, 1, 1'b0, 7, 5,     1'b1, 1'b0, 1'b0, 0, 1, 0};
    tbl[11] = '{1'b0, 1'b0, 1,  2, 1'b0, 7, 5,     1'b1, 1'b0, 1'b0, 0, 0, 1};
    tbl[12] = '{1'b0, 1'b0, 8,  2, 1'b0, 7, 5,     1'b1, 1'b0, 1'b0, 2, 0, 8};
    tbl[13] = '{1'b0, 1'b1, 1,  3, 1'b1, 2, 2,     1'b1, 1'b0, 1'b0, 0, 0, 0};
    tbl[14] = '{1'b0, 1'b0, 1,  3, 1'b1, 2, 2,     1'b1, 1'b0, 1'b0, 0, 0, 0};
    // false start
    tbl[15] = '{1'b1, 1'b0, 5,  1, 1'b0, 2, 2,     1'b1, 1'b0, 1'b0, 0, 1, 0};
    tbl[16] = '{1'b0, 1'b1, 1,  4, 1'b0, 2, 2,     1'b1, 1'b1, 1'b0, 0, 0, 0};
    tbl[17] = '{1'b0, 1'b0, 1,  4, 1'b0, 2, 2,     1'b1, 1'b1, 1'b0, 0, 0, 0};
    tbl[18] = '{1'b1, 1'b0, 1,  1, 1'b0, 2, 2,     1'b1, 1'b0, 1'b0, 0, 1, 0};
    tbl[19] = '{1'b0, 1'b0, 12, 2, 1'b0, 2, 2,     1'b1, 1'b0, 1'b0, 0, 0, 1};
    // timeout: one cycle before and at the 20th tick
    tbl[20] = '{1'b0, 1'b0, 79, 2, 1'b0, 2, 2,     1'b1, 1'b0, 1'b0, 19, 0, 79};
    tbl[21] = '{1'b0, 1'b0, 1,  4, 1'b0, 2, 2,     1'b1, 1'b0, 1'b1, 1, 0, 0};
    // stop coincident with the 4th tick
    tbl[22] = '{1'b1, 1'b0, 1,  1, 1'b0, 2, 2,     1'b1, 1'b0, 1'b0, 0, 1, 0};
    tbl[23] = '{1'b0, 1'b0, 12, 2, 1'b0, 2, 2,     1'b1, 1'b0, 1'b0, 0, 0, 1};
    tbl[24] = '{1'b0, 1'b0, 15, 2, 1'b0, 2, 2,     1'b1, 1'b0, 1'b0, 3, 0, 15};
    tbl[25] = '{1'b0, 1'b1, 1,  3, 1'b1, 3, 2,     1'b1, 1'b0, 1'b0, 0, 0, 0};
    tbl[26] = '{1'b0, 1'b0, 1,  3, 1'b1, 3, 2,     1'b1, 1'b0, 1'b0, 0, 0, 0};
    // stop before the first tick: zero is a valid best
    tbl[27] = '{1'b1, 1'b0, 1,  1, 1'b0, 3, 2,     1'b1, 1'b0, 1'b0, 0, 1, 0};
    tbl[28] = '{1'b0, 1'b0, 12, 2, 1'b0, 3, 2,     1'b1, 1'b0, 1'b0, 0, 0, 1};
    tbl[29] = '{1'b0, 1'b1, 1,  3, 1'b1, 0, 0,     1'b1, 1'b0, 1'b0, 0, 0, 0};
    tbl[30] = '{1'b0, 1'b0, 1,  3, 1'b1, 0, 0,     1'b1, 1'b0, 1'b0, 0, 0, 0};
    // stop edge in DONE is ignored
    tbl[31] = '{1'b0, 1'b1, 2,  3, 1'b1, 0, 0,     1'b1, 1'b0, 1'b0, 0, 0, 0};
    tbl[32] = '{1'b0, 1'b0, 1,  3, 1'b1, 0, 0,     1'b1, 1'b0, 1'b0, 0, 0, 0};

    // reset
    reset = 1'b1;
    bus.request_test = 1'b0;
    bus.stop_test    = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b0;
    ce_n = 0; clr_n = 0; act_n = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst state",        bus.state,        0);
    check("rst test_active",  bus.test_active,  0);
    check("rst result_valid", bus.result_valid, 0);
    check("rst result_time",  bus.result_time,  0);
    check("rst best_time",    bus.best_time,    32'h3FFF);
    check("rst best_valid",   bus.best_valid,   0);
    check("rst false_start",  bus.false_start,  0);
    check("rst timeout",      bus.timeout,      0);
    check("rst pulses",       ce_n + clr_n,     0);

    // table
    for (int i = 0; i < NV; i++) begin
      run_cycles(tbl[i].req, tbl[i].stop, tbl[i].cyc);
      check($sformatf("v%0d state", i),        bus.state,        tbl[i].st);
      check($sformatf("v%0d result_valid", i), bus.result_valid, tbl[i].rv);
      check($sformatf("v%0d result_time", i),  bus.result_time,  tbl[i].rt);
      check($sformatf("v%0d best_time", i),    bus.best_time,    tbl[i].bt);
      check($sformatf("v%0d best_valid", i),   bus.best_valid,   tbl[i].bv);
      check($sformatf("v%0d false_start", i),  bus.false_start,  tbl[i].fs);
      check($sformatf("v%0d timeout", i),      bus.timeout,      tbl[i].to);
      check($sformatf("v%0d count_enable", i), ce_n,             tbl[i].ce);
      check($sformatf("v%0d count_clear", i),  clr_n,            tbl[i].clr);
      check($sformatf("v%0d active_cycles", i), act_n,           tbl[i].act);
    end

    // reset in the middle of WAIT aborts immediately and drops the best
    run_cycles(1'b1, 1'b0, 5);
    check("midwait state", bus.state, 1);
    reset = 1'b1;
    run_cycles(1'b0, 1'b0, 1);
    check("midrst state",       bus.state,        0);
    check("midrst best_valid",  bus.best_valid,   0);
    check("midrst best_time",   bus.best_time,    32'h3FFF);
    check("midrst result_time", bus.result_time,  0);
    check("midrst count_clear", bus.count_clear,  0);
    reset = 1'b0;
    run_cycles(1'b0, 1'b0, 3);
    check("post rst idle", bus.state, 0);

    // a held request button starts exactly one test
    run_cycles(1'b1, 1'b0, 30);
    check("held req clears", clr_n,     1);
    check("held req state",  bus.state, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
